// File: rtl/hilo_unit_pkg.sv
// hilo_unit_pkg: shared definitions for the HI/LO multiply/divide unit.
//   - HiLoOp encodings produced by the decoder
//   - default multicycle latencies
//   - FSM state type and small op-classification helpers
package hilo_unit_pkg;

  localparam logic [3:0] NOP_FOR_HI_LO = 4'd0;
  localparam logic [3:0] MULT_OP       = 4'd1;
  localparam logic [3:0] MULTU_OP      = 4'd2;
  localparam logic [3:0] DIV_OP        = 4'd3;
  localparam logic [3:0] DIVU_OP       = 4'd4;
  localparam logic [3:0] MFHI_OP       = 4'd5;
  localparam logic [3:0] MFLO_OP       = 4'd6;
  localparam logic [3:0] MTHI_OP       = 4'd7;
  localparam logic [3:0] MTLO_OP       = 4'd8;

  localparam int DEFAULT_MULT_CYCLES = 5;
  localparam int DEFAULT_DIV_CYCLES  = 10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } hilo_state_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == MULT_OP) || (op == MULTU_OP) || (op == DIV_OP) || (op == DIVU_OP);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == DIV_OP) || (op == DIVU_OP);
  endfunction

endpackage

// File: rtl/hilo_arith.sv
// hilo_arith: purely combinational multiply/divide datapath.
// Ports:
//   op          in  4   HiLoOp (only MULT/MULTU/DIV/DIVU produce a result)
//   a, b        in  32  operands (rs, rt)
//   result      out 64  {hi, lo}: product, or {remainder, quotient}
//   div_by_zero out 1   divide op with b == 0; result is 0 in that case
module hilo_arith
  import hilo_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] q_s, r_s, q_u, r_u;

  // The low 64 bits of the product of sign-extended operands equal the
  // signed 32x32 product, so one unsigned multiplier form covers both.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  always_comb begin
    q_s = 32'd0;
    r_s = 32'd0;
    q_u = 32'd0;
    r_u = 32'd0;
    if (b != 32'd0) begin
      q_u = a / b;
      r_u = a % b;
      // Most-negative / -1 overflows; pin it to the wrapped quotient.
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q_s = 32'h8000_0000;
        r_s = 32'd0;
      end else begin
        q_s = $signed(a) / $signed(b);
        r_s = $signed(a) % $signed(b);
      end
    end
  end

  always_comb begin
    result      = 64'd0;
    div_by_zero = is_div(op) && (b == 32'd0);
    case (op)
      MULT_OP:  result = prod_s;
      MULTU_OP: result = prod_u;
      DIV_OP:   result = {r_s, q_s};
      DIVU_OP:  result = {r_u, q_u};
      default:  result = 64'd0;
    endcase
  end

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: E-stage multiply/divide unit owning the HI/LO registers.
// Ports:
//   clk      in  1   clock
//   reset    in  1   synchronous active-low reset
//   Valid    in  1   E-stage instruction valid
//   HiLoOp   in  4   decoder op code (see hilo_unit_pkg)
//   A, B     in  32  forwarded rs / rt
//   Start    out 1   multicycle op accepted this cycle (combinational)
//   Busy     out 1   multicycle op in flight (registered)
//   HiLoOut  out 32  mfhi/mflo read value, else 0
//   HI, LO   out 32  architectural registers
//
// state  | meaning
// S_IDLE | no op in flight; Start, mthi and mtlo are accepted
// S_RUN  | counting down; pending result commits when counter == 1
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Valid,
  input  logic [3:0]  HiLoOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HiLoOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  hilo_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;

  logic [63:0] arith_result;
  logic        arith_dbz;

  hilo_arith u_arith (
    .op          (HiLoOp),
    .a           (A),
    .b           (B),
    .result      (arith_result),
    .div_by_zero (arith_dbz)
  );

  assign Busy  = (state_q == S_RUN);
  assign Start = Valid && is_muldiv(HiLoOp) && !Busy;
  assign HI    = hi_q;
  assign LO    = lo_q;

  // Read-out shows only committed HI/LO; pending results are never bypassed.
  always_comb begin
    HiLoOut = 32'd0;
    if (HiLoOp == MFHI_OP)      HiLoOut = hi_q;
    else if (HiLoOp == MFLO_OP) HiLoOut = lo_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d   = S_RUN;
          cnt_d     = is_div(HiLoOp) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
          pend_hi_d = arith_result[63:32];
          pend_lo_d = arith_result[31:0];
          // Divide by zero still occupies the unit but leaves HI/LO alone.
          pend_wr_d = !arith_dbz;
        end else if (Valid && HiLoOp == MTHI_OP) begin
          hi_d = A;
        end else if (Valid && HiLoOp == MTLO_OP) begin
          lo_d = A;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Execute-stage multiply/divide unit for the P6 pipeline.
- Consumes the 4-bit HiLoOp produced by the decoder alongside the forwarded E-stage operands.
- Owns the HI/LO registers and runs mult/multu/div/divu as fixed-latency multicycle operations.
- Provides Start/Busy for the hazard unit, and HiLoOut (the mfhi/mflo read value) for the E-stage result mux.

Parameters:
- MULT_CYCLES, 5, number of cycles Busy stays high for mult/multu.
- DIV_CYCLES, 10, number of cycles Busy stays high for div/divu.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset (asserted when reset == 0); one clock domain only.
- Valid  input  1  E-stage instruction is valid (not a bubble).
- HiLoOp  input  4  operation code from the decoder; encodings are in the shared package.
- A  input  32  forwarded rs value.
- B  input  32  forwarded rt value.
- Start  output  1  combinational: Valid && HiLoOp ∈ {MULT, MULTU, DIV, DIVU} && !Busy.
- Busy  output  1  registered: a multicycle operation is in flight.
- HiLoOut  output  32  combinational: HI when HiLoOp == MFHI, LO when HiLoOp == MFLO, else 0.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- Reset (reset == 0 at a rising edge): HI = 0, LO = 0, Busy = 0, counter = 0, pending results = 0. Reset overrides any in-flight operation, and the pending result is discarded.
- States: IDLE (Busy = 0) and RUN (Busy = 1); counter is 4 bits.
- IDLE to RUN: at the edge where Start = 1:
  - the result is computed from A/B and latched into pending HI/LO registers;
  - counter is loaded with MULT_CYCLES or DIV_CYCLES;
  - Busy = 1 from the next cycle.
- RUN: the counter decrements each edge. At the edge where counter == 1:
  - HI/LO take the pending values;
  - Busy drops to 0;
  - the state returns to IDLE.
- Timing: Busy is high for exactly N cycles, and new HI/LO are visible in the cycle Busy first reads 0. A back-to-back Start in that same cycle is legal.
- mult: signed 32×32 → 64; HI = product[63:32], LO = product[31:0]. multu is the same but unsigned.
- div (signed): LO = quotient, truncated toward zero; HI = remainder, which takes the sign of the dividend. divu: unsigned.
- Divide by zero (B == 0): Busy still runs DIV_CYCLES, but at completion HI/LO are left unchanged.
- mthi / mtlo, when Valid && !Busy: HI (or LO) = A at the edge, single cycle; Busy is unaffected.
- Any Valid HiLoOp other than NOP or MFHI/MFLO while Busy = 1 is ignored and leaves no side effects. The hazard unit is required to stall D whenever the D instruction is a HiLo op and (Start || Busy).
- mfhi / mflo: pure combinational read of the current HI/LO. No bypass of pending results.
- Valid = 0: no state change except normal RUN progress.
- Undefined HiLoOp values: treated as NOP.

Decomposition:
- Shared package / defines file holds:
  - HiLoOp encodings: NOP_FOR_HI_LO = 0, MULT_OP = 1, MULTU_OP = 2, DIV_OP = 3, DIVU_OP = 4, MFHI_OP = 5, MFLO_OP = 6, MTHI_OP = 7, MTLO_OP = 8;
  - default latency constants.
- One natural sub-module, hilo_arith: purely combinational. Inputs are op, A and B; outputs are the 64-bit {hi, lo} result and a div_by_zero flag. This keeps the FSM and counter in hilo_unit separate from the arithmetic.

Test Plan:
- Signed multiply, A = 0xFFFFFFFF, B = 0x00000002, MULT, Valid = 1 → Start = 1 in cycle 0; Busy = 1 in cycles 1–5; HI = 0xFFFFFFFF and LO = 0xFFFFFFFE in cycle 6.
- Unsigned multiply, same operands, MULTU → HI = 0x00000001, LO = 0xFFFFFFFE after 5 busy cycles.
- Signed and unsigned divide:
  - A = 0xFFFFFFF9 (−7), B = 2, DIV → Busy for 10 cycles, then LO = 0xFFFFFFFD and HI = 0xFFFFFFFF.
  - DIVU 7 / 0 → Busy for 10 cycles, HI/LO keep their prior values.
- Move-to/move-from:
  - MTHI A = 0x12345678 → HI = 0x12345678 next cycle.
  - MFHI → HiLoOut = 0x12345678 combinationally.
  - MTLO issued in cycle 2 of a MULT → ignored; LO ends up as the product.
- Back-to-back: MULT, then DIV issued in the first cycle Busy = 0 → the DIV is accepted; Busy stays high 10 more cycles with no gap cycle required.
- Reset mid-operation: reset = 0 in cycle 3 of a DIV → the next cycle shows Busy = 0 and HI = LO = 0, and the pending result is never written.
